// File: rtl/rf_wb_unit.sv
`timescale 1ns/1ps
// rf_wb_unit: owns the register-file write port, queues write-backs in order, forwards pending values
//   clk, rst_n                   clock, asynchronous active-low reset
//   mem_valid/ready/waddr/wdata  load-result write request (priority source)
//   alu_valid/ready/waddr/wdata  ALU-result write request
//   hold                         stalls issue from the FIFO head
//   rf_wen/rf_waddr/rf_wdata     registered register-file write port
//   chk_addrN -> chk_hitN/dataN  combinational lookup of youngest pending write
//   busy                         writes still queued or being written
module rf_wb_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [ADDR_WIDTH-1:0] mem_waddr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [ADDR_WIDTH-1:0] alu_waddr,
   input  logic [DATA_WIDTH-1:0] alu_wdata,
   input  logic                  hold,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   input  logic [ADDR_WIDTH-1:0] chk_addr1,
   input  logic [ADDR_WIDTH-1:0] chk_addr2,
   output logic                  chk_hit1,
   output logic                  chk_hit2,
   output logic [DATA_WIDTH-1:0] chk_data1,
   output logic [DATA_WIDTH-1:0] chk_data2,
   output logic                  busy
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   logic [PW:0] count;
   logic [PW-1:0] wptr, rptr, idx;
   logic [ADDR_WIDTH-1:0] q_addr [DEPTH];
   logic [DATA_WIDTH-1:0] q_data [DEPTH];
   logic take_mem, take_alu, push, pop;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [DATA_WIDTH-1:0] in_data;
   // ready looks only at registered occupancy, so a same-cycle pop never frees a slot early
   assign mem_ready = count < FULL;
   assign alu_ready = mem_ready && !mem_valid;
   assign take_mem  = mem_valid && mem_ready;
   assign take_alu  = alu_valid && alu_ready;
   assign in_addr   = take_mem ? mem_waddr : alu_waddr;
   assign in_data   = take_mem ? mem_wdata : alu_wdata;
   // x0 writes finish the handshake but are never queued
   assign push      = (take_mem || take_alu) && in_addr != '0;
   assign pop       = count != '0 && !hold;
   assign busy      = count != '0 || rf_wen;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         count    <= '0;
         wptr     <= '0;
         rptr     <= '0;
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         count  <= count + (PW+1)'(push) - (PW+1)'(pop);
         rf_wen <= pop;
         if (push) wptr <= wptr + PW'(1);
         if (pop) begin
            rptr     <= rptr + PW'(1);
            rf_waddr <= q_addr[rptr];
            rf_wdata <= q_data[rptr];
         end
      end
   always_ff @(posedge clk)
      if (push) begin
         q_addr[wptr] <= in_addr;
         q_data[wptr] <= in_data;
      end
   // scan oldest to newest so later matches override: output stage < older FIFO < newer FIFO
   always_comb begin
      idx       = rptr;
      chk_hit1  = rf_wen && rf_waddr == chk_addr1;
      chk_data1 = chk_hit1 ? rf_wdata : '0;
      chk_hit2  = rf_wen && rf_waddr == chk_addr2;
      chk_data2 = chk_hit2 ? rf_wdata : '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rptr + PW'(k);
         if ((PW+1)'(k) < count && q_addr[idx] == chk_addr1) begin
            chk_hit1  = 1'b1;
            chk_data1 = q_data[idx];
         end
         if ((PW+1)'(k) < count && q_addr[idx] == chk_addr2) begin
            chk_hit2  = 1'b1;
            chk_data2 = q_data[idx];
         end
      end
      if (chk_addr1 == '0) begin
         chk_hit1  = 1'b0;
         chk_data1 = '0;
      end
      if (chk_addr2 == '0) begin
         chk_hit2  = 1'b0;
         chk_data2 = '0;
      end
   end
endmodule

// File: tb/tb_rf_wb_unit.sv
`timescale 1ns/1ps
// tb_rf_wb_unit: random and directed stimulus against a queue-based reference with an issue scoreboard
module tb_rf_wb_unit;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int D  = 4;
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;
   logic clk, rst_n, mem_valid, mem_ready, alu_valid, alu_ready, hold, rf_wen, chk_hit1, chk_hit2, busy;
   logic [AW-1:0] mem_waddr, alu_waddr, rf_waddr, chk_addr1, chk_addr2;
   logic [DW-1:0] mem_wdata, alu_wdata, rf_wdata, chk_data1, chk_data2;
   int checks = 0;
   int errors = 0;
   ent_t mq[$];
   ent_t exp_q[$];
   logic m_wen = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   logic am, aa;
   logic [DW:0] f1, f2;
   ent_t e, got;
   rf_wb_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
      .hold(hold), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
      .chk_data1(chk_data1), .chk_data2(chk_data2), .busy(busy)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // youngest pending value: newest queued entry first, then the write in flight
   function automatic logic [DW:0] fwd(input logic [AW-1:0] a);
      if (a == '0) return '0;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].a == a) return {1'b1, mq[i].d};
      if (m_wen && m_addr == a) return {1'b1, m_data};
      return '0;
   endfunction
   always @(negedge rst_n) begin
      mq.delete();
      exp_q.delete();
      m_wen  = 1'b0;
      m_addr = '0;
      m_data = '0;
   end
   always @(posedge clk) if (rst_n) begin
      am = mem_valid && mq.size() < D;
      aa = alu_valid && !mem_valid && mq.size() < D;
      if (mq.size() != 0 && !hold) begin
         e      = mq.pop_front();
         m_wen  = 1'b1;
         m_addr = e.a;
         m_data = e.d;
      end else m_wen = 1'b0;
      if (am && mem_waddr != '0) begin
         mq.push_back({mem_waddr, mem_wdata});
         exp_q.push_back({mem_waddr, mem_wdata});
      end else if (aa && alu_waddr != '0) begin
         mq.push_back({alu_waddr, alu_wdata});
         exp_q.push_back({alu_waddr, alu_wdata});
      end
   end
   always @(negedge clk) begin
      chk("mem_ready", mem_ready, mq.size() < D);
      chk("alu_ready", alu_ready, mq.size() < D && !mem_valid);
      chk("busy", busy, mq.size() != 0 || m_wen);
      chk("rf_wen", rf_wen, m_wen);
      chk("rf_waddr", rf_waddr, m_addr);
      chk("rf_wdata", rf_wdata, m_data);
      f1 = fwd(chk_addr1);
      f2 = fwd(chk_addr2);
      chk("chk_hit1", chk_hit1, f1[DW]);
      chk("chk_data1", chk_data1, f1[DW-1:0]);
      chk("chk_hit2", chk_hit2, f2[DW]);
      chk("chk_data2", chk_data2, f2[DW-1:0]);
   end
   always @(negedge clk) if (rf_wen) begin
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL issue_extra: got write %0h=%0h expected none at %0t", rf_waddr, rf_wdata, $time);
      end else begin
         got = exp_q.pop_front();
         chk("issue_order", {rf_waddr, rf_wdata}, got);
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input bit m, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      bit ok = 1'b0;
      if (m) begin
         mem_valid = 1'b1;
         mem_waddr = a;
         mem_wdata = d;
      end else begin
         alu_valid = 1'b1;
         alu_waddr = a;
         alu_wdata = d;
      end
      while (!ok && n < 100) begin
         #1 ok = m ? mem_ready : alu_ready;
         tick();
         n++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no ready expected ready within 100 cycles");
      end
      mem_valid = 1'b0;
      alu_valid = 1'b0;
   endtask
   initial begin
      int sent, c;
      rst_n = 1'b0;
      {mem_valid, alu_valid, hold} = '0;
      {mem_waddr, alu_waddr, chk_addr1, chk_addr2} = '0;
      {mem_wdata, alu_wdata} = '0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      // priority: both valid, mem wins, alu follows next cycle
      mem_valid = 1'b1; mem_waddr = 3; mem_wdata = 32'hAAAA0000;
      alu_valid = 1'b1; alu_waddr = 4; alu_wdata = 32'h1;
      chk_addr1 = 3; chk_addr2 = 4;
      tick();
      mem_valid = 1'b0;
      tick();
      alu_valid = 1'b0;
      repeat (4) tick();
      // x0 is accepted and dropped
      chk_addr1 = 0;
      send(0, 0, 32'hDEADBEEF);
      repeat (3) tick();
      // fill under hold, a fifth request waits, release drains in order
      hold = 1'b1;
      chk_addr1 = 2; chk_addr2 = 4;
      for (int r = 1; r <= 4; r++) send(0, AW'(r), DW'(r * 16));
      alu_valid = 1'b1; alu_waddr = 5; alu_wdata = 32'h55;
      repeat (3) tick();
      hold = 1'b0;
      send(0, 5, 32'h55);
      repeat (8) tick();
      // youngest of two same-address writes is forwarded
      hold = 1'b1;
      chk_addr2 = 7;
      send(0, 7, 32'h11);
      send(1, 7, 32'h22);
      repeat (2) tick();
      hold = 1'b0;
      repeat (6) tick();
      // stream with hold toggling every 3 cycles to wrap the pointers
      sent = 0;
      c = 0;
      while (sent < 10 && c < 200) begin
         hold = ((c / 3) % 2) == 1;
         alu_valid = 1'b1;
         alu_waddr = AW'(sent % 7 + 1);
         alu_wdata = $urandom;
         chk_addr1 = AW'($urandom_range(0, 7));
         #1 if (alu_ready) sent++;
         tick();
         c++;
      end
      alu_valid = 1'b0;
      hold = 1'b0;
      repeat (12) tick();
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         mem_valid = ($urandom_range(0, 3) == 0);
         alu_valid = ($urandom_range(0, 1) == 0);
         mem_waddr = AW'($urandom_range(0, 7));
         alu_waddr = AW'($urandom_range(0, 7));
         mem_wdata = $urandom;
         alu_wdata = $urandom;
         hold      = ($urandom_range(0, 3) == 0);
         chk_addr1 = AW'($urandom_range(0, 7));
         chk_addr2 = AW'($urandom_range(0, 7));
         tick();
      end
      {mem_valid, alu_valid, hold} = '0;
      repeat (10) tick();
      // asynchronous reset with three pending entries and a write in flight
      hold = 1'b1;
      for (int r = 1; r <= 4; r++) send(0, AW'(r + 8), $urandom);
      hold = 1'b0;
      tick();
      chk("pre_reset_wen", rf_wen, 1);
      chk("pre_reset_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rf_wen", rf_wen, 0);
      chk("async_busy", busy, 0);
      chk("async_alu_ready", alu_ready, 1);
      @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (6) tick();
      chk("post_reset_busy", busy, 0);
      // drain whatever remains
      c = 0;
      while ((mq.size() != 0 || m_wen) && c < 50) begin
         tick();
         c++;
      end
      chk("drained", mq.size() == 0 && exp_q.size() == 0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
